bf_core: RTL and testbench
==========================

BF_CORE -- requirements
Module: bf_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning datapath, register and memory word width (8 or 16 only).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning memory address and PC width.
REQ-003 SHALL have port clk input 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst input 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port mem_req output 1, bus request.
REQ-006 SHALL have port mem_we output 1, write strobe, valid while mem_req.
REQ-007 SHALL have port mem_addr output ADDR_W, bus address.
REQ-008 SHALL have port mem_wdata output DATA_W, store data.
REQ-009 SHALL have port mem_rdata input DATA_W, read data, valid when mem_ready.
REQ-010 SHALL have port mem_ready input 1, transfer complete.
REQ-011 SHALL have port retire output 1, one-cycle pulse per completed instruction.
REQ-012 SHALL have port halted output 1, core stopped.
REQ-013 SHALL have port dbg_pc output ADDR_W, current PC.

Function
REQ-014 SHALL decode a 16-bit instruction: op=[15:12], r0=[11:8], r1=[7:4], r2=[3:0], imm=[7:0] zero-extended to DATA_W; 16 registers of DATA_W.
REQ-015 SHALL implement: JMP 0 pc<=R[r0]; LOD 1 R[r0]<=mem[R[r1]]; STR 2 mem[R[r1]]<=R[r0]; ADD 3 R[r0]<=R[r1]+R[r2]; ADDI 4 R[r0]<=R[r0]+imm; LODI 5 R[r0]<=imm; NAND 6 R[r0]<=~(R[r1]&R[r2]); JEQZ 7 if R[r1]==0 pc<=R[r0].
REQ-016 SHALL wrap all arithmetic modulo 2^DATA_W; addresses take the low ADDR_W bits of register values, zero-extended if DATA_W<ADDR_W.
REQ-017 SHALL run FSM states FETCH, DECODE, EXEC, MEM, WB, HALT; FETCH->DECODE after last beat; DECODE->EXEC; EXEC->MEM for LOD/STR, ->FETCH for JMP/JEQZ, else ->WB; MEM->WB (LOD) or ->FETCH (STR) on mem_ready; WB->FETCH.
REQ-018 SHALL fetch 16/DATA_W beats per instruction, big-endian (first beat at pc = inst[15:8] when DATA_W=8), advancing pc by 16/DATA_W after fetch, wrapping mod 2^ADDR_W.
REQ-019 SHALL hold mem_req high with addr/we/wdata stable until the cycle mem_ready is sampled high; a transfer completes on req&&ready; next request MAY start the following cycle.
REQ-020 SHALL ignore mem_ready while mem_req is low.
REQ-021 SHALL give zero-wait latency: ALU/LODI 3+beats cycles, JMP/JEQZ 2+beats, LOD 4+beats, STR 3+beats; each wait state adds one cycle.
REQ-022 SHALL pulse retire in the cycle the FSM returns to FETCH from WB, EXEC (jump) or MEM (store).
REQ-023 SHALL let a taken jump override the post-fetch pc increment; a jump to its own address loops without halting.

Reset
REQ-024 SHALL on rst low immediately clear pc, mem_req, mem_we, retire, halted to 0, mem_addr/mem_wdata to 0, state to FETCH; register contents SHALL also clear to 0.
REQ-025 SHALL abandon any in-flight transfer on reset; first fetch request at address 0 in the first clock after rst deasserts.

Configuration
REQ-026 SHALL with BF_CORE_ILLEGAL_TRAP_EN defined, treat opcodes 8-15 as traps: enter HALT, assert halted, keep mem_req low, no retire, exit only by reset.
REQ-027 SHALL without BF_CORE_ILLEGAL_TRAP_EN, execute opcodes 8-15 as NOP (retire, no state change); halted SHALL stay 0.

Structure
REQ-028 SHALL take opcode constants, field positions and the state enum from shared package bf_core_pkg.
REQ-029 SHALL place the register file in sub-module bf_core_regfile: 16 x DATA_W, two async read ports, one sync write port, async active-low clear.

Verification
REQ-030 DATA_W=8, zero-wait: LODI r1,5; LODI r2,7; ADD r3,r1,r2 -> R3=12, three retire pulses, ADD retires 5 cycles after its first fetch request.
REQ-031 LODI r1,0xFF; ADDI r1,2 -> R1=0x01 (wrap).
REQ-032 STR r1 to address 0x40 with 3 wait states -> mem_req held 4 cycles, addr 0x40, wdata=R1, we=1 throughout.
REQ-033 JEQZ r4,r5 with R5=0, R4=0x20 -> next fetch at 0x20; with R5=1 -> next fetch at pc+2.
REQ-034 Opcode 0xF fetched: with macro -> halted=1, no further mem_req; without -> retire, next fetch at pc+2.
REQ-035 rst low mid-LOD wait -> mem_req drops same cycle, pc=0; after release first fetch at 0x00; DATA_W=16 run fetches one beat per instruction with pc step 1.

Source files
------------

// File: rtl/bf_core_pkg.sv
// bf_core_pkg: shared definitions for the bf_core processor.
// Holds the opcode constants, the instruction field positions, the
// register-file geometry and the FSM state enum used by bf_core and
// bf_core_regfile. The helper functions classify opcodes for the FSM.
package bf_core_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_AW   = 4;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int R0_MSB  = 11;
    localparam int R0_LSB  = 8;
    localparam int R1_MSB  = 7;
    localparam int R1_LSB  = 4;
    localparam int R2_MSB  = 3;
    localparam int R2_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_JMP  = 4'h0;
    localparam logic [3:0] OP_LOD  = 4'h1;
    localparam logic [3:0] OP_STR  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LODI = 4'h5;
    localparam logic [3:0] OP_NAND = 4'h6;
    localparam logic [3:0] OP_JEQZ = 4'h7;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    function automatic logic writes_reg(input logic [3:0] op);
        return op inside {OP_LOD, OP_ADD, OP_ADDI, OP_LODI, OP_NAND};
    endfunction

    function automatic logic is_jump(input logic [3:0] op);
        return op == OP_JMP || op == OP_JEQZ;
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return op == OP_LOD || op == OP_STR;
    endfunction

endpackage

// File: rtl/bf_core_regfile.sv
// bf_core_regfile: 16 x DATA_W register file.
// Ports:
//   clk, rst            clock, asynchronous active-low clear of all entries
//   ra_addr / ra_data   asynchronous read port A
//   rb_addr / rb_data   asynchronous read port B
//   we, wa, wd          synchronous write port (write enable, address, data)
module bf_core_regfile
    import bf_core_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    assign ra_data = regs_q[ra_addr];
    assign rb_data = regs_q[rb_addr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (we) begin
            regs_q[wa] <= wd;
        end
    end

endmodule

// File: rtl/bf_core.sv
// bf_core: multi-cycle 16-bit-instruction processor with a req/ready memory bus.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   mem_req, mem_we      bus request and write strobe (held until mem_ready)
//   mem_addr, mem_wdata  bus address and store data
//   mem_rdata, mem_ready read data and transfer-complete handshake
//   retire               one-cycle pulse per completed instruction
//   halted               core stopped (trap)
//   dbg_pc               current program counter
// Configuration: define BF_CORE_ILLEGAL_TRAP_EN to halt on opcodes 8-15;
// otherwise they execute as NOPs.
module bf_core
    import bf_core_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              retire,
    output logic              halted,
    output logic [ADDR_W-1:0] dbg_pc
);

    localparam int BEATS = 16 / DATA_W;
    localparam logic LAST_BEAT = 1'(BEATS - 1);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(BEATS);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [15:0]       ir_q, ir_d;
    logic              beat_q, beat_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic              retire_q, retire_d;
    logic              halted_q, halted_d;

    logic [3:0]        op, r0, r1, r2, rb_addr;
    logic [DATA_W-1:0] imm, ra_data, rb_data, alu;
    logic              xfer, rf_we;

    // Register values become addresses by taking the low ADDR_W bits,
    // zero-extending when the register is narrower than the address.
    function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] v);
        return ADDR_W'({{ADDR_W{1'b0}}, v});
    endfunction

    assign op      = ir_q[OP_MSB:OP_LSB];
    assign r0      = ir_q[R0_MSB:R0_LSB];
    assign r1      = ir_q[R1_MSB:R1_LSB];
    assign r2      = ir_q[R2_MSB:R2_LSB];
    assign imm     = DATA_W'(ir_q[IMM_MSB:IMM_LSB]);
    // Port A always reads r1; port B reads r2 for two-source ops, else r0.
    assign rb_addr = (op == OP_ADD || op == OP_NAND) ? r2 : r0;
    assign xfer    = mem_req_q && mem_ready;
    assign alu     = op == OP_ADD  ? ra_data + rb_data :
                     op == OP_ADDI ? rb_data + imm :
                     op == OP_LODI ? imm :
                                     ~(ra_data & rb_data);
    assign rf_we   = state_q == S_WB && writes_reg(op);

    bf_core_regfile #(.DATA_W(DATA_W)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .ra_addr(r1),
        .ra_data(ra_data),
        .rb_addr(rb_addr),
        .rb_data(rb_data),
        .we     (rf_we),
        .wa     (r0),
        .wd     (res_q)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        beat_d      = beat_q;
        res_d       = res_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        retire_d    = 1'b0;
        halted_d    = halted_q;
        case (state_q)
            S_FETCH: begin
                if (!mem_req_q) begin
                    // Only reached right after reset; every other entry
                    // into FETCH already issues the first beat.
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc_q;
                end else if (mem_ready) begin
                    // Big-endian assembly: earlier beats shift up.
                    ir_d = 16'((32'(ir_q) << DATA_W) | 32'(mem_rdata));
                    if (beat_q == LAST_BEAT) begin
                        state_d   = S_DECODE;
                        mem_req_d = 1'b0;
                        beat_d    = 1'b0;
                        pc_d      = pc_q + PC_STEP;
                    end else begin
                        beat_d     = beat_q + 1'b1;
                        mem_addr_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            S_DECODE: begin
`ifdef BF_CORE_ILLEGAL_TRAP_EN
                state_d  = op[3] ? S_HALT : S_EXEC;
                halted_d = op[3];
`else
                state_d = S_EXEC;
`endif
            end
            S_EXEC: begin
                res_d = alu;
                if (is_jump(op)) begin
                    state_d    = S_FETCH;
                    retire_d   = 1'b1;
                    pc_d       = (op == OP_JMP || ra_data == '0) ? to_addr(rb_data) : pc_q;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc_d;
                end else if (is_mem(op)) begin
                    state_d     = S_MEM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = op == OP_STR;
                    mem_addr_d  = to_addr(ra_data);
                    mem_wdata_d = rb_data;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (xfer) begin
                    res_d     = mem_rdata;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (op == OP_STR) begin
                        state_d    = S_FETCH;
                        retire_d   = 1'b1;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_q;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                state_d    = S_FETCH;
                retire_d   = 1'b1;
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b0;
                mem_addr_d = pc_q;
            end
            S_HALT: begin
                mem_req_d = 1'b0;
                halted_d  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            beat_q      <= 1'b0;
            res_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            retire_q    <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            beat_q      <= beat_d;
            res_q       <= res_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            retire_q    <= retire_d;
            halted_q    <= halted_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign retire    = retire_q;
    assign halted    = halted_q;
    assign dbg_pc    = pc_q;

endmodule

// File: tb/tb_bf_core.sv
// tb_bf_core: scoreboard bench for bf_core; an instruction-level model
// predicts every bus transfer and per-instruction latency.
module tb_bf_core;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } xfer_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_req, mem_we, retire, halted;
    logic [7:0] mem_addr, mem_wdata, dbg_pc;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_ready = 1'b0;

    logic        mem_req16, mem_we16, retire16, halted16;
    logic [7:0]  mem_addr16, dbg_pc16;
    logic [15:0] mem_wdata16, mem_rdata16;

    int vectors = 0;
    int miscompares = 0;

    xfer_t      exp_q[$];
    int         lat_q[$];
    xfer_t      front;
    logic [7:0] img[256];
    logic [7:0] bmem[256];
    bit         iss_halted = 0;
    bit         lat_chk = 0;
    int         fixed_wait = 0;
    int         max_wait = 0;
    bit         pend = 0;
    int         wl = 0;
    int         cyc = 0;
    int         last_ret = 0;
    bit         seen_req = 0;
    logic [7:0] exp16 = 0;
    int         n16 = 0;

    always #5 clk = ~clk;

    bf_core #(.DATA_W(8), .ADDR_W(8)) u_dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .retire(retire), .halted(halted), .dbg_pc(dbg_pc)
    );

    // A second core with 16-bit words fetching an endless run of LODIs.
    assign mem_rdata16 = {8'h51, mem_addr16};

    bf_core #(.DATA_W(16), .ADDR_W(8)) u_dut16 (
        .clk(clk), .rst(rst), .mem_req(mem_req16), .mem_we(mem_we16),
        .mem_addr(mem_addr16), .mem_wdata(mem_wdata16), .mem_rdata(mem_rdata16),
        .mem_ready(1'b1), .retire(retire16), .halted(halted16), .dbg_pc(dbg_pc16)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Instruction-level reference: walks the program and queues the bus
    // transfers and cycle counts each instruction must produce.
    task automatic iss_run(input int n);
        logic [7:0]  r[16];
        logic [7:0]  m[256];
        logic [7:0]  pc, imm;
        logic [15:0] ins;
        logic [3:0]  op, a, b, c;
        for (int i = 0; i < 16; i++) r[i] = 8'h00;
        for (int i = 0; i < 256; i++) m[i] = img[i];
        pc = 8'h00;
        iss_halted = 0;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({1'b0, pc, 8'h00});
            exp_q.push_back({1'b0, pc + 8'd1, 8'h00});
            ins = {m[pc], m[pc + 8'd1]};
            pc = pc + 8'd2;
            {op, a, b, c} = ins;
            imm = ins[7:0];
            case (op)
                4'h0: begin pc = r[a]; lat_q.push_back(4); end
                4'h1: begin exp_q.push_back({1'b0, r[b], 8'h00}); r[a] = m[r[b]]; lat_q.push_back(6); end
                4'h2: begin exp_q.push_back({1'b1, r[b], r[a]}); m[r[b]] = r[a]; lat_q.push_back(5); end
                4'h3: begin r[a] = r[b] + r[c]; lat_q.push_back(5); end
                4'h4: begin r[a] = r[a] + imm; lat_q.push_back(5); end
                4'h5: begin r[a] = imm; lat_q.push_back(5); end
                4'h6: begin r[a] = ~(r[b] & r[c]); lat_q.push_back(5); end
                4'h7: begin if (r[b] == 8'h00) pc = r[a]; lat_q.push_back(4); end
                default: begin
`ifdef BF_CORE_ILLEGAL_TRAP_EN
                    iss_halted = 1;
                    return;
`else
                    lat_q.push_back(5);
`endif
                end
            endcase
        end
    endtask

    // Memory responder and bus monitor: picks wait states, checks every
    // cycle of a pending request against the predicted transfer.
    always @(negedge clk) begin
        if (!rst) begin
            pend = 0;
            mem_ready = 1'b0;
        end else if (mem_req) begin
            if (!pend) begin
                pend = 1;
                wl = fixed_wait >= 0 ? fixed_wait : int'($urandom_range(0, max_wait));
            end
            if (exp_q.size() == 0) begin
                if (iss_halted) chk("req_after_halt", mem_req, 0);
            end else begin
                front = exp_q[0];
                chk("bus_addr", mem_addr, front.addr);
                chk("bus_we", mem_we, front.we);
                if (front.we) chk("bus_wdata", mem_wdata, front.wdata);
            end
            if (wl == 0) begin
                mem_ready = 1'b1;
                mem_rdata = bmem[mem_addr];
                if (mem_we) bmem[mem_addr] = mem_wdata;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                pend = 0;
            end else begin
                mem_ready = 1'b0;
                wl--;
            end
        end else begin
            if (pend) chk("req_dropped", mem_req, 1);
            pend = 0;
            // Idle-cycle noise on ready must be ignored by the core.
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = 8'($urandom);
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            seen_req = 0;
        end else begin
            if (!seen_req && mem_req) begin
                seen_req = 1;
                last_ret = cyc;
            end
            if (retire) begin
                if (lat_chk && lat_q.size() != 0) chk("latency", cyc - last_ret, lat_q.pop_front());
                last_ret = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            exp16 = 8'h00;
            n16 = 0;
        end else if (mem_req16 && n16 < 24) begin
            chk("fetch16_addr", mem_addr16, exp16);
            chk("fetch16_pc", dbg_pc16, exp16);
            chk("fetch16_we", mem_we16, 0);
            chk("fetch16_wdata", mem_wdata16, 0);
            chk("fetch16_retire", retire16, n16 != 0);
            chk("halted16", halted16, 0);
            exp16++;
            n16++;
        end
    end

    task automatic run(input int n, input int fw, input int mw, input bit lc);
        int t;
        rst = 1'b0;
        fixed_wait = fw;
        max_wait = mw;
        lat_chk = lc;
        repeat (2) @(negedge clk);
        exp_q.delete();
        lat_q.delete();
        iss_run(n);
        for (int i = 0; i < 256; i++) bmem[i] = img[i];
        #2 rst = 1'b1;
        for (t = 0; t < 8000 && exp_q.size() != 0; t++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        repeat (12) @(negedge clk);
        chk("halted", halted, iss_halted);
    endtask

    initial begin
        int t;
        logic [3:0] op;
        logic [7:0] prog[42];
        prog = '{8'h51, 8'h05, 8'h52, 8'h07, 8'h33, 8'h12, 8'h54, 8'h40,
                 8'h23, 8'h40, 8'h51, 8'hFF, 8'h41, 8'h02, 8'h21, 8'h40,
                 8'h54, 8'h20, 8'h74, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h55, 8'h01, 8'h74, 8'h50, 8'hF0, 8'h00, 8'h56, 8'h28,
                 8'h06, 8'h00};
        #3 rst = 1'b0;
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_retire", retire, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", dbg_pc, 0);

        for (int i = 0; i < 256; i++) img[i] = i < 42 ? prog[i] : 8'h00;
        run(30, 0, 0, 1);
        run(30, 3, 0, 0);

        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 256; i += 2) begin
                op = $urandom_range(0, 31) == 0 ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
                img[i] = {op, 4'($urandom)};
                img[i + 1] = 8'($urandom);
            end
            run(150, s == 0 ? 0 : -1, 3, s == 0);
        end

        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        img[0] = 8'h51; img[1] = 8'h30; img[2] = 8'h12; img[3] = 8'h10;
        rst = 1'b0;
        fixed_wait = 6;
        lat_chk = 0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        lat_q.delete();
        iss_run(2);
        for (int i = 0; i < 256; i++) bmem[i] = img[i];
        #2 rst = 1'b1;
        for (t = 0; t < 300 && !(mem_req && mem_addr == 8'h30); t++) @(negedge clk);
        chk("lod_pending", mem_req && mem_addr == 8'h30, 1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_req", mem_req, 0);
        chk("midrst_pc", dbg_pc, 0);
        chk("midrst_addr", mem_addr, 0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        lat_q.delete();
        #2 rst = 1'b1;
        @(negedge clk);
        chk("refetch_req", mem_req, 1);
        chk("refetch_addr", mem_addr, 0);
        chk("refetch_we", mem_we, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
